noc_req_arbiter: RTL
====================

# noc_req_arbiter

Round-robin arbiter that shares the single L1.5 NoC request port between the cache-side requesters: instruction-cache refill, data-cache load and write-buffer store. It bounds in-flight transactions per requester with credit counters. It serialises non-idempotent (uncached I/O) accesses behind all outstanding traffic. The block sits between the write-through L1 caches and the NoC adapter.

## Interface
Parameters:
- NumReq, 3: number of requesters; index 0 = icache, 1 = dcache load, 2 = write-buffer store
- PayloadWidth, 128: opaque request payload width (type, address, data, tid), passed through untouched
- MaxOutstanding, 7: maximum in-flight transactions per requester (1..15)
- CntW, $clog2(MaxOutstanding+1): width of each credit counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NumReq  per-requester request valid
- req_nc_i  in  NumReq  request targets a non-idempotent region
- req_payload_i  in  NumReq*PayloadWidth  per-requester payload, requester r at bits [r*PayloadWidth +: PayloadWidth]
- req_ready_o  out  NumReq  grant; handshake when valid & ready
- noc_valid_o  out  1  registered request to the NoC adapter
- noc_ready_i  in  1  NoC adapter accepts
- noc_payload_o  out  PayloadWidth  registered payload
- noc_src_o  out  $clog2(NumReq)  requester index of noc_payload_o
- rtrn_valid_i  in  1  one transaction completed (response or store ack)
- rtrn_src_i  in  $clog2(NumReq)  requester owning the completion
- idle_o  out  1  all counters zero and output register empty
- err_o  out  1  one-cycle pulse on completion for a requester whose counter is 0

## Operation
- Output register: one entry (valid, payload, src). It is free when empty, or when full with noc_ready_i high in the same cycle (pass-through refill).
- Eligibility of requester r: req_valid_i[r], cnt[r] < MaxOutstanding, and output register free.
- Extra condition when req_nc_i[r] = 1: all counters are 0 and the output register is empty. The pass-through case does not count as empty.
- While any nc request has been waiting at least 1 cycle, no new cached grants are issued to other requesters, so the nc request cannot starve.
- Arbitration: round-robin pointer rr. At most one grant per cycle: the first eligible index from rr upward, wrapping. req_ready_o[g] = 1 only for the granted g.
- On grant g: load the output register; cnt[g] increments; rr becomes (g+1) mod NumReq.
- rtrn_valid_i: cnt[rtrn_src_i] decrements.
- Grant and completion to the same requester in the same cycle: counter unchanged.
- Completion when counter is 0: counter stays 0 and err_o pulses.
- Credits are consumed at grant, not at NoC acceptance, so requests held in the output register are counted.
- Requester contract: payload and valid stay stable until handshake. req_valid_i must not depend on req_ready_o.

## Timing
- Reset values: noc_valid_o=0, noc_payload_o=0, noc_src_o=0, all cnt=0, rr=0, err_o=0, idle_o=1. req_ready_o=0 during reset.
- req_ready_o is combinational from req_valid_i, req_nc_i, counters, rr, output-register state and noc_ready_i.
- Latency: a grant in cycle N gives noc_valid_o=1 in cycle N+1.
- noc_payload_o and noc_src_o stay stable while noc_valid_o=1 and noc_ready_i=0.
- Throughput: 1 request/cycle while noc_ready_i stays high.
- An nc request is granted no earlier than the cycle after the last counter reaches 0 and the output register has drained.
- Reset asserted mid-operation discards the output register and all counters in the next cycle. Completions arriving afterwards may raise err_o; this is expected.

## Test plan
- All three requesters valid continuously, noc_ready_i=1, no returns: grants follow 0,1,2,0,1,2. Each counter reaches 7 after 21 grants, after which req_ready_o=0. A single return for src 1 allows exactly one more grant to requester 1.
- noc_ready_i=0 for 5 cycles with requester 0 pending: exactly one grant. noc_payload_o is held for 5 cycles and no further grants are issued. When ready rises, back-to-back transfer resumes with no gap.
- cnt[2]=3 outstanding, then requester 1 raises nc: it is blocked, and cached requesters 0 and 2 are also held off after 1 cycle. Three returns for src 2 follow; the nc grant comes one cycle after cnt[2]=0 and the output register is empty.
- Grant to requester 0 and rtrn_src_i=0 in the same cycle with cnt[0]=4: cnt[0] stays 4 and idle_o=0.
- rtrn_valid_i with src 2 while cnt[2]=0: err_o=1 for one cycle and counters are unchanged.
- Reset asserted while noc_valid_o=1 and counters are nonzero: the next cycle shows all reset values and idle_o=1.

Source files
------------

// File: rtl/noc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_req_arbiter
// Description : Round-robin arbiter sharing the single L1.5 NoC request port
//               between the icache refill (0), dcache load (1) and
//               write-buffer store (2) requesters. Per-requester credit
//               counters bound in-flight transactions. Non-idempotent (nc)
//               requests are serialised behind all outstanding traffic.
//
// Ports       : clk_i          clock, rising edge
//               rst_i          synchronous active-high reset
//               req_valid_i    per-requester request valid
//               req_nc_i       per-requester non-idempotent flag
//               req_payload_i  packed payloads, requester r at [r*W +: W]
//               req_ready_o    one-hot grant (combinational)
//               noc_valid_o    registered request valid to the NoC adapter
//               noc_ready_i    NoC adapter accepts
//               noc_payload_o  registered payload
//               noc_src_o      requester index of noc_payload_o
//               rtrn_valid_i   one transaction completed
//               rtrn_src_i     requester owning the completion
//               idle_o         no credits outstanding and output register empty
//               err_o          one-cycle pulse: completion with no credit out
//
// Revision    : 1.0  initial release
// ============================================================================
module noc_req_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int PAYLOAD_WIDTH   = 128,
    parameter int MAX_OUTSTANDING = 7,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    input  logic [NUM_REQ-1:0]               req_nc_i,
    input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_payload_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    output logic                             noc_valid_o,
    input  logic                             noc_ready_i,
    output logic [PAYLOAD_WIDTH-1:0]         noc_payload_o,
    output logic [$clog2(NUM_REQ)-1:0]       noc_src_o,
    input  logic                             rtrn_valid_i,
    input  logic [$clog2(NUM_REQ)-1:0]       rtrn_src_i,
    output logic                             idle_o,
    output logic                             err_o
);

    localparam int SRC_W = $clog2(NUM_REQ);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]         r_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]       r_nc_wait;
    logic [SRC_W-1:0]         r_rr;
    logic                     r_out_valid;
    logic [PAYLOAD_WIDTH-1:0] r_out_payload;
    logic [SRC_W-1:0]         r_out_src;
    logic                     r_err;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [NUM_REQ-1:0]       w_cnt_zero;
    logic [NUM_REQ-1:0]       w_cnt_room;
    logic [NUM_REQ-1:0]       w_elig;
    logic [NUM_REQ-1:0]       w_gnt;
    logic [NUM_REQ-1:0]       w_rtrn_sel;
    logic [NUM_REQ-1:0]       w_dec;
    logic                     w_gnt_any;
    logic [SRC_W-1:0]         w_gnt_idx;
    logic [PAYLOAD_WIDTH-1:0] w_gnt_payload;
    logic                     w_out_free;
    logic                     w_out_empty;
    logic                     w_all_zero;
    logic                     w_nc_block;
    logic                     w_rtrn_err;

    // Free also covers the pass-through case (full, but drained this cycle).
    // Empty is strictly "no entry held", which is what nc requests need.
    assign w_out_empty = !r_out_valid;
    assign w_out_free  = !r_out_valid || noc_ready_i;
    assign w_all_zero  = &w_cnt_zero;

    // An nc request that lost arbitration last cycle and is still pending
    // freezes cached grants so the outstanding traffic can drain.
    assign w_nc_block  = |(r_nc_wait & req_valid_i & req_nc_i);

    generate
        for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
            assign w_cnt_zero[r] = (r_cnt[r] == '0);
            assign w_cnt_room[r] = (r_cnt[r] < CNT_W'(MAX_OUTSTANDING));

            assign w_elig[r] = req_valid_i[r] && w_cnt_room[r] && w_out_free &&
                               (req_nc_i[r] ? (w_all_zero && w_out_empty)
                                            : !w_nc_block);

            assign w_rtrn_sel[r] = rtrn_valid_i && (rtrn_src_i == SRC_W'(r));
            // A completion against an empty counter is an error, not a decrement.
            assign w_dec[r]      = w_rtrn_sel[r] && !w_cnt_zero[r];
        end
    endgenerate

    // Any completion that does not hit a live credit (empty counter or
    // out-of-range source) is flagged.
    assign w_rtrn_err = rtrn_valid_i && !(|w_dec);

    // ------------------------------------------------------------------------
    // Round-robin pick: first eligible index from r_rr upward, wrapping.
    // ------------------------------------------------------------------------
    always_comb begin : p_arb
        int idx;
        idx       = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(r_rr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_gnt_any && w_elig[idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = SRC_W'(idx);
            end
        end
    end

    always_comb begin : p_gnt_vec
        w_gnt         = '0;
        w_gnt_payload = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_gnt_any && (w_gnt_idx == SRC_W'(r))) begin
                w_gnt[r]      = 1'b1;
                w_gnt_payload = req_payload_i[r*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

    assign req_ready_o = rst_i ? '0 : w_gnt;

    // ------------------------------------------------------------------------
    // Credit counters. Grant and completion to the same requester in the
    // same cycle cancel out.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NUM_REQ; r++) begin
            if (rst_i) begin
                r_cnt[r] <= '0;
            end else if (w_gnt[r] && !w_dec[r]) begin
                r_cnt[r] <= r_cnt[r] + CNT_W'(1);
            end else if (!w_gnt[r] && w_dec[r]) begin
                r_cnt[r] <= r_cnt[r] - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // nc wait tracking, round-robin pointer and error pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_nc_wait <= '0;
            r_rr      <= '0;
            r_err     <= 1'b0;
        end else begin
            r_nc_wait <= req_valid_i & req_nc_i & ~w_gnt;
            r_err     <= w_rtrn_err;
            if (w_gnt_any) begin
                r_rr <= (w_gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0
                                                            : w_gnt_idx + SRC_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register. A grant is only issued when the register is free, so
    // loading on grant never overwrites an entry the NoC has not taken.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid   <= 1'b0;
            r_out_payload <= '0;
            r_out_src     <= '0;
        end else if (w_gnt_any) begin
            r_out_valid   <= 1'b1;
            r_out_payload <= w_gnt_payload;
            r_out_src     <= w_gnt_idx;
        end else if (noc_ready_i) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign noc_valid_o   = r_out_valid;
    assign noc_payload_o = r_out_payload;
    assign noc_src_o     = r_out_src;
    assign idle_o        = w_all_zero && w_out_empty;
    assign err_o         = r_err;

endmodule
`default_nettype wire
